swerve_rotate_scheduler: RTL and testbench

//  Schedules wheel-rotation commands across NUM_WHEELS angle_to_pwm channels; queues host commands in order.

---
 rtl/swerve_pkg.sv | 28 ++
 rtl/swerve_rotate_scheduler_sync_fifo.sv | 57 +++++
 rtl/swerve_rotate_scheduler.sv | 152 +++++++++++++++
 tb/tb_swerve_rotate_scheduler.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/swerve_pkg.sv
// Shared definitions for the swerve rotation scheduler: channel state encoding,
// default angle width and the wrap-around angle distance helper.
package swerve_pkg;

  localparam int ANGLE_W = 12;

  typedef enum logic [2:0] {
    CH_IDLE  = 3'd0,
    CH_START = 3'd1,
    CH_RUN   = 3'd2,
    CH_ABORT = 3'd3,
    CH_DONE  = 3'd4,
    CH_ERROR = 3'd5
  } ch_state_e;

  // Shortest distance between two angles on a circle of 2^width counts.
  function automatic logic [31:0] angle_dist(input logic [31:0] a, input logic [31:0] b,
                                             input int unsigned width);
    logic [31:0] mask;
    logic [31:0] fwd;
    logic [31:0] bwd;
    mask = (32'd1 << width) - 32'd1;
    fwd  = (a - b) & mask;
    bwd  = (b - a) & mask;
    return (fwd < bwd) ? fwd : bwd;
  endfunction

endpackage

// File: rtl/swerve_rotate_scheduler_sync_fifo.sv
// In-order command queue with full/empty flags, same-cycle push/pop and a flush
// that empties the queue and drops any push presented in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_data  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full && !i_flush;
  assign w_pop   = i_pop && !o_empty && !i_flush;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/swerve_rotate_scheduler.sv
// Queues host rotation commands and dispatches them in order to per-wheel
// angle_to_pwm channels, capping concurrent motion and handling timeout/retry.
module swerve_rotate_scheduler #(
  parameter int NUM_WHEELS  = 4,
  parameter int ANGLE_W     = swerve_pkg::ANGLE_W,
  parameter int FIFO_DEPTH  = 4,
  parameter int MAX_ACTIVE  = 2,
  parameter int TIMEOUT_CYC = 2000000,
  parameter int MAX_RETRIES = 2,
  parameter int ANGLE_TOL   = 2,
  localparam int WW         = $clog2(NUM_WHEELS)
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          i_cmd_valid,
  output logic                          o_cmd_ready,
  input  logic [WW-1:0]                 i_cmd_wheel,
  input  logic [ANGLE_W-1:0]            i_cmd_angle,
  input  logic                          i_abort_all,
  input  logic [NUM_WHEELS-1:0]         i_err_clear,
  input  logic [NUM_WHEELS*ANGLE_W-1:0] i_current_angle,
  input  logic [NUM_WHEELS-1:0]         i_angle_done,
  output logic [NUM_WHEELS*ANGLE_W-1:0] o_target_angle,
  output logic [NUM_WHEELS-1:0]         o_angle_update,
  output logic [NUM_WHEELS-1:0]         o_abort_angle,
  output logic [NUM_WHEELS-1:0]         o_wheel_busy,
  output logic [NUM_WHEELS-1:0]         o_wheel_error,
  output logic [NUM_WHEELS-1:0]         o_cmd_done,
  output logic                          o_sched_busy,
  output logic [NUM_WHEELS*3-1:0]       o_dbg_state
);

  import swerve_pkg::*;

  localparam int RW = $clog2(MAX_RETRIES + 1) + 1;

  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic                  w_pop;
  logic [WW+ANGLE_W-1:0] w_head;
  logic [WW-1:0]         w_head_wheel;
  logic [ANGLE_W-1:0]    w_head_angle;
  logic [ANGLE_W-1:0]    w_head_cur;
  logic                  w_head_near;
  logic [NUM_WHEELS-1:0] w_idle;
  logic [NUM_WHEELS-1:0] w_active;
  logic [WW:0]           w_active_cnt;

  // Valid/ready: a command is taken on every cycle with i_cmd_valid && o_cmd_ready,
  // except while i_abort_all is high, when it is dropped along with the queue.
  sync_fifo #(
    .WIDTH (WW + ANGLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .i_push  (i_cmd_valid),
    .i_pop   (w_pop),
    .i_flush (i_abort_all),
    .i_data  ({i_cmd_wheel, i_cmd_angle}),
    .o_data  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign o_cmd_ready                  = !w_fifo_full;
  assign {w_head_wheel, w_head_angle} = w_head;
  assign w_head_cur  = i_current_angle[w_head_wheel*ANGLE_W +: ANGLE_W];
  assign w_head_near = angle_dist(32'(w_head_angle), 32'(w_head_cur), ANGLE_W) <= 32'(ANGLE_TOL);

  always_comb begin
    w_active_cnt = '0;
    for (int i = 0; i < NUM_WHEELS; i++) begin
      w_active_cnt = w_active_cnt + (WW+1)'(w_active[i]);
    end
  end

  // Head-of-line dispatch only: a blocked head stalls everything behind it.
  assign w_pop = !w_fifo_empty && !i_abort_all && w_idle[w_head_wheel] &&
                 (w_active_cnt < (WW+1)'(MAX_ACTIVE));

  assign o_sched_busy = !w_fifo_empty || (|o_wheel_busy);

  for (genvar g = 0; g < NUM_WHEELS; g++) begin : g_ch
    ch_state_e          r_state;
    ch_state_e          w_next;
    logic [23:0]        r_tcnt;
    logic [RW-1:0]      r_retry;
    logic               r_flush;
    logic [ANGLE_W-1:0] r_target;
    logic               w_disp;

    assign w_disp = w_pop && (w_head_wheel == WW'(g));

    always_comb begin
      w_next = r_state;
      case (r_state)
        CH_IDLE:  if (w_disp) w_next = w_head_near ? CH_DONE : CH_START;
        CH_START: w_next = i_abort_all ? CH_ABORT : CH_RUN;
        CH_RUN: begin
          if (i_abort_all)                             w_next = CH_ABORT;
          else if (i_angle_done[g])                    w_next = CH_DONE;
          else if (r_tcnt == 24'(TIMEOUT_CYC - 1))     w_next = CH_ABORT;
        end
        CH_ABORT: begin
          if (r_flush || i_abort_all)                  w_next = CH_IDLE;
          else if (r_retry < RW'(MAX_RETRIES))         w_next = CH_START;
          else                                         w_next = CH_ERROR;
        end
        CH_DONE:  w_next = CH_IDLE;
        CH_ERROR: if (i_err_clear[g]) w_next = CH_IDLE;
        default:  w_next = CH_IDLE;
      endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        r_state  <= CH_IDLE;
        r_target <= '0;
        r_tcnt   <= '0;
        r_retry  <= '0;
        r_flush  <= 1'b0;
      end else begin
        r_state <= w_next;
        if (w_disp) r_target <= w_head_angle;
        if (r_state == CH_START)     r_tcnt <= '0;
        else if (r_state == CH_RUN)  r_tcnt <= r_tcnt + 1'b1;
        if (r_state == CH_ABORT && w_next == CH_START) r_retry <= r_retry + 1'b1;
        // A global abort exhausts retries and marks the abort as a flush, not a failure.
        if (i_abort_all && (r_state == CH_START || r_state == CH_RUN || r_state == CH_ABORT)) begin
          r_retry <= RW'(MAX_RETRIES);
          r_flush <= 1'b1;
        end
        if (w_next == CH_IDLE) begin
          r_retry <= '0;
          r_flush <= 1'b0;
        end
      end
    end

    assign w_idle[g]         = (r_state == CH_IDLE);
    assign w_active[g]       = (r_state == CH_START) || (r_state == CH_RUN) || (r_state == CH_ABORT);
    assign o_angle_update[g] = (r_state == CH_START);
    assign o_abort_angle[g]  = (r_state == CH_ABORT);
    assign o_cmd_done[g]     = (r_state == CH_DONE);
    assign o_wheel_error[g]  = (r_state == CH_ERROR);
    assign o_wheel_busy[g]   = (r_state != CH_IDLE) && (r_state != CH_ERROR);
    assign o_target_angle[g*ANGLE_W +: ANGLE_W] = r_target;
    assign o_dbg_state[g*3 +: 3] = r_state;
  end

endmodule

// File: tb/tb_swerve_rotate_scheduler.sv
// Directed bench for swerve_rotate_scheduler: behavioural angle_done models,
// an event scoreboard fed by the stimulus and drained by a monitor.
module tb_swerve_rotate_scheduler;

  localparam int NW = 4;
  localparam int AW = 12;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_wheel;
  logic [AW-1:0]    cmd_angle;
  logic             abort_all;
  logic [NW-1:0]    err_clear;
  logic [NW*AW-1:0] current_angle;
  logic [NW-1:0]    angle_done;
  logic [NW*AW-1:0] target_angle;
  logic [NW-1:0]    angle_update;
  logic [NW-1:0]    abort_angle;
  logic [NW-1:0]    wheel_busy;
  logic [NW-1:0]    wheel_error;
  logic [NW-1:0]    cmd_done;
  logic             sched_busy;
  logic [NW*3-1:0]  dbg_state;

  swerve_rotate_scheduler #(.TIMEOUT_CYC(200)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .i_cmd_valid     (cmd_valid),
    .o_cmd_ready     (cmd_ready),
    .i_cmd_wheel     (cmd_wheel),
    .i_cmd_angle     (cmd_angle),
    .i_abort_all     (abort_all),
    .i_err_clear     (err_clear),
    .i_current_angle (current_angle),
    .i_angle_done    (angle_done),
    .o_target_angle  (target_angle),
    .o_angle_update  (angle_update),
    .o_abort_angle   (abort_angle),
    .o_wheel_busy    (wheel_busy),
    .o_wheel_error   (wheel_error),
    .o_cmd_done      (cmd_done),
    .o_sched_busy    (sched_busy),
    .o_dbg_state     (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [15:0] ev(input int kind, input int w, input int a);
    return {kind[1:0], w[1:0], a[11:0]};
  endfunction

  function automatic void check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endfunction

  function automatic void sb_event(input logic [15:0] got);
    logic [15:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL event_unexpected: got %0h expected none (cycle %0d)", got, cyc);
    end else begin
      e = exp_q.pop_front();
      check("event", 64'(got), 64'(e));
    end
  endfunction

  int upd_cyc [NW];
  int done_cyc [NW];
  int done_in_cyc [NW];
  bit track_busy = 1'b0;
  int max_busy = 0;

  // Monitor: samples on the falling edge, converts output pulses into events.
  initial begin
    forever begin
      @(negedge clock);
      if (reset_n) begin
        if (track_busy) begin
          int bc;
          bc = $countones(wheel_busy);
          if (bc > max_busy) max_busy = bc;
        end else begin
          max_busy = 0;
        end
        for (int w = 0; w < NW; w++) begin
          if (angle_done[w]) done_in_cyc[w] = cyc;
          if (angle_update[w]) begin
            upd_cyc[w] = cyc;
            sb_event(ev(1, w, int'(target_angle[w*AW +: AW])));
          end
          if (abort_angle[w]) sb_event(ev(2, w, int'(target_angle[w*AW +: AW])));
          if (cmd_done[w]) begin
            done_cyc[w] = cyc;
            sb_event(ev(3, w, int'(target_angle[w*AW +: AW])));
          end
        end
      end
    end
  end

  // Behavioural angle_to_pwm: done pulses done_delay cycles after angle_update (0 = never).
  int done_delay [NW];
  int done_cnt [NW];
  initial begin
    angle_done = '0;
    for (int w = 0; w < NW; w++) done_cnt[w] = 0;
    forever begin
      @(posedge clock);
      #1;
      for (int w = 0; w < NW; w++) begin
        angle_done[w] = 1'b0;
        if (!reset_n || abort_angle[w]) done_cnt[w] = 0;
        else if (done_cnt[w] > 0) begin
          done_cnt[w]--;
          if (done_cnt[w] == 0) angle_done[w] = 1'b1;
        end
        if (angle_update[w] && done_delay[w] > 0) done_cnt[w] = done_delay[w];
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input int w, input int a, output int pc);
    int guard = 0;
    while (!cmd_ready && guard < 1000) begin
      tick();
      guard++;
    end
    check("push_ready", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_wheel = w[1:0];
    cmd_angle = a[AW-1:0];
    pc = cyc;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (sched_busy && n < budget) begin
      tick();
      n++;
    end
    check({name, "_idle"}, 64'(sched_busy), 64'd0);
  endtask

  task automatic check_quiet(input string name);
    check({name, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    check({name, "_outputs"},
          64'({angle_update, abort_angle, wheel_busy, wheel_error, cmd_done, sched_busy}), 64'd0);
    check({name, "_target"}, 64'(target_angle), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed tests ----------------
  initial begin
    int pc;
    reset_n       = 1'b0;
    cmd_valid     = 1'b0;
    cmd_wheel     = '0;
    cmd_angle     = '0;
    abort_all     = 1'b0;
    err_clear     = '0;
    current_angle = {12'd10, 12'd10, 12'd10, 12'd10};
    for (int w = 0; w < NW; w++) done_delay[w] = 0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_quiet("rst");
    tick();
    reset_n = 1'b1;
    tick();

    // 1: single command, latency push->update and done->cmd_done
    done_delay[0] = 50;
    exp_q.push_back(ev(1, 0, 100));
    exp_q.push_back(ev(3, 0, 100));
    push(0, 100, pc);
    wait_idle(300, "t1");
    check("t1_update_latency", 64'(upd_cyc[0] - pc), 64'd2);
    check("t1_done_latency", 64'(done_cyc[0] - done_in_cyc[0]), 64'd1);
    check("t1_queue_drained", 64'(exp_q.size()), 64'd0);

    // 2: four wheels, at most two moving; w2 starts the cycle after w0 completes
    for (int w = 0; w < NW; w++) done_delay[w] = 30;
    track_busy = 1'b1;
    exp_q.push_back(ev(1, 0, 100));
    exp_q.push_back(ev(1, 1, 100));
    exp_q.push_back(ev(3, 0, 100));
    exp_q.push_back(ev(3, 1, 100));
    exp_q.push_back(ev(1, 2, 100));
    exp_q.push_back(ev(1, 3, 100));
    exp_q.push_back(ev(3, 2, 100));
    exp_q.push_back(ev(3, 3, 100));
    for (int w = 0; w < NW; w++) push(w, 100, pc);
    wait_idle(500, "t2");
    check("t2_max_busy", 64'(max_busy), 64'd2);
    check("t2_w2_start", 64'(upd_cyc[2] - done_cyc[0]), 64'd1);
    track_busy = 1'b0;
    check("t2_queue_drained", 64'(exp_q.size()), 64'd0);

    // 3: tolerance via wrap (d=2 skips motion) and just outside it (d=3)
    current_angle[2*AW-1:AW] = 12'd1;
    done_delay[1] = 5;
    exp_q.push_back(ev(3, 1, 4095));
    push(1, 4095, pc);
    wait_idle(50, "t3a");
    check("t3_target", 64'(target_angle[2*AW-1:AW]), 64'd4095);
    exp_q.push_back(ev(1, 1, 4094));
    exp_q.push_back(ev(3, 1, 4094));
    push(1, 4094, pc);
    wait_idle(50, "t3b");
    check("t3_queue_drained", 64'(exp_q.size()), 64'd0);

    // 4: timeout with two retries then sticky error; queued commands stall behind it
    done_delay[2] = 0;
    for (int r = 0; r < 3; r++) begin
      exp_q.push_back(ev(1, 2, 500));
      exp_q.push_back(ev(2, 2, 500));
    end
    push(2, 500, pc);
    wait_idle(1000, "t4");
    check("t4_error", 64'(wheel_error), 64'h4);
    done_delay[2] = 5;
    done_delay[0] = 5;
    push(2, 600, pc);
    push(0, 200, pc);
    repeat (20) tick();
    check("t4_stall_sched_busy", 64'(sched_busy), 64'd1);
    check("t4_stall_wheels", 64'(wheel_busy), 64'd0);
    exp_q.push_back(ev(1, 2, 600));
    exp_q.push_back(ev(1, 0, 200));
    exp_q.push_back(ev(3, 2, 600));
    exp_q.push_back(ev(3, 0, 200));
    err_clear = 4'b0100;
    tick();
    err_clear = '0;
    check("t4_error_cleared", 64'(wheel_error), 64'd0);
    wait_idle(100, "t4b");
    check("t4_queue_drained", 64'(exp_q.size()), 64'd0);

    // 5: fill the queue, then abort_all flushes it and stops the running wheels
    done_delay[0] = 0;
    done_delay[1] = 0;
    exp_q.push_back(ev(1, 0, 300));
    exp_q.push_back(ev(1, 1, 310));
    push(0, 300, pc);
    push(1, 310, pc);
    push(2, 320, pc);
    push(3, 330, pc);
    push(0, 340, pc);
    push(1, 350, pc);
    check("t5_full", 64'(cmd_ready), 64'd0);
    exp_q.push_back(ev(2, 0, 300));
    exp_q.push_back(ev(2, 1, 310));
    abort_all = 1'b1;
    cmd_valid = 1'b1;
    cmd_wheel = 2'd3;
    cmd_angle = 12'd999;
    tick();
    abort_all = 1'b0;
    cmd_valid = 1'b0;
    check("t5_ready_after_flush", 64'(cmd_ready), 64'd1);
    check("t5_abort_pulse", 64'(abort_angle), 64'h3);
    tick();
    tick();
    check("t5_sched_idle", 64'(sched_busy), 64'd0);
    check("t5_no_error", 64'(wheel_error), 64'd0);
    repeat (5) tick();
    check("t5_queue_drained", 64'(exp_q.size()), 64'd0);

    // 6: asynchronous reset mid-RUN, then normal operation resumes
    done_delay[3] = 0;
    exp_q.push_back(ev(1, 3, 1000));
    push(3, 1000, pc);
    repeat (10) tick();
    check("t6_running", 64'(wheel_busy), 64'h8);
    reset_n = 1'b0;
    #1;
    check_quiet("t6_rst");
    tick();
    reset_n = 1'b1;
    tick();
    done_delay[3] = 5;
    exp_q.push_back(ev(1, 3, 50));
    exp_q.push_back(ev(3, 3, 50));
    push(3, 50, pc);
    wait_idle(50, "t6");
    check("t6_update_latency", 64'(upd_cyc[3] - pc), 64'd2);
    repeat (5) tick();
    check("final_queue_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
